// File: rtl/seven_seg_pkg.sv
// Shared glyph constants and polarity helper for the seven-segment display driver.
package seven_seg_pkg;

    // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_0    = 7'h3F;
    localparam logic [6:0] GLYPH_1    = 7'h06;
    localparam logic [6:0] GLYPH_2    = 7'h5B;
    localparam logic [6:0] GLYPH_3    = 7'h4F;
    localparam logic [6:0] GLYPH_4    = 7'h66;
    localparam logic [6:0] GLYPH_5    = 7'h6D;
    localparam logic [6:0] GLYPH_6    = 7'h7D;
    localparam logic [6:0] GLYPH_7    = 7'h07;
    localparam logic [6:0] GLYPH_8    = 7'h7F;
    localparam logic [6:0] GLYPH_9    = 7'h6F;
    localparam logic [6:0] GLYPH_A    = 7'h77;
    localparam logic [6:0] GLYPH_B    = 7'h7C;
    localparam logic [6:0] GLYPH_C    = 7'h39;
    localparam logic [6:0] GLYPH_D    = 7'h5E;
    localparam logic [6:0] GLYPH_E    = 7'h79;
    localparam logic [6:0] GLYPH_F    = 7'h71;
    localparam logic [6:0] GLYPH_DASH = 7'h40;
    localparam logic [6:0] GLYPH_OFF  = 7'h00;

    // Converts an active-high pattern to the pin polarity of the display
    function automatic logic [6:0] apply_polarity(input logic [6:0] seg, input logic act_low);
        return act_low ? ~seg : seg;
    endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational hex nibble to active-high seven-segment glyph lookup.
module seven_seg_glyph
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] glyph_c
);

    // Unknown nibbles fall through to the dash
    always_comb begin
        glyph_c = GLYPH_DASH;
        case (nibble)
            4'h0:    glyph_c = GLYPH_0;
            4'h1:    glyph_c = GLYPH_1;
            4'h2:    glyph_c = GLYPH_2;
            4'h3:    glyph_c = GLYPH_3;
            4'h4:    glyph_c = GLYPH_4;
            4'h5:    glyph_c = GLYPH_5;
            4'h6:    glyph_c = GLYPH_6;
            4'h7:    glyph_c = GLYPH_7;
            4'h8:    glyph_c = GLYPH_8;
            4'h9:    glyph_c = GLYPH_9;
            4'hA:    glyph_c = GLYPH_A;
            4'hB:    glyph_c = GLYPH_B;
            4'hC:    glyph_c = GLYPH_C;
            4'hD:    glyph_c = GLYPH_D;
            4'hE:    glyph_c = GLYPH_E;
            4'hF:    glyph_c = GLYPH_F;
            default: glyph_c = GLYPH_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed N-digit seven-segment scan driver with tear-free frame updates,
// blanking, blinking, decimal points, leading-zero suppression and an anode ghost gap.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter bit          SEG_ACT_LOW  = 1'b1,
    parameter bit          AN_ACT_LOW   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_mask,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    lz_en,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_tick
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned PTR_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned BLINK_W = $clog2(BLINK_FRAMES) + 1;
    localparam int unsigned DIG_W   = 4 * NUM_DIGITS;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [PTR_W-1:0]   PTR_LAST   = PTR_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);

    typedef struct packed {
        logic [DIG_W-1:0]      digits;
        logic [NUM_DIGITS-1:0] dp;
        logic [NUM_DIGITS-1:0] blank;
        logic [NUM_DIGITS-1:0] blink;
    } frame_t;

    frame_t                  shadow_q, shadow_d;
    frame_t                  active_q, active_d;
    frame_t                  frame_in_c;
    logic [SCAN_W-1:0]       scan_cnt_q, scan_cnt_d;
    logic [PTR_W-1:0]        ptr_q, ptr_d;
    logic [BLINK_W-1:0]      blink_cnt_q, blink_cnt_d;
    logic                    blink_phase_q, blink_phase_d;
    logic                    slot_end_c, wrap_c;

    logic [3:0]              nibble_c;
    logic [6:0]              glyph_c;
    logic [NUM_DIGITS-1:0]   lz_dark_c;
    logic [NUM_DIGITS-1:0]   an_onehot_c;
    logic                    zero_run_c, dark_c, dp_sel_c;
    logic [6:0]              seg_d;
    logic                    dp_d;
    logic [NUM_DIGITS-1:0]   an_d;
    logic                    frame_tick_d;

    assign frame_in_c = {digits_in, dp_in, blank_mask, blink_mask};

    seven_seg_glyph u_glyph (
        .nibble  (nibble_c),
        .glyph_c (glyph_c)
    );

    // Scan/blink counters and shadow->active frame transfer on the wrap edge
    always_comb begin
        scan_cnt_d    = scan_cnt_q;
        ptr_d         = ptr_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        shadow_d      = shadow_q;
        active_d      = active_q;
        frame_tick_d  = 1'b0;

        slot_end_c = (scan_cnt_q == SCAN_LAST);
        wrap_c     = slot_end_c && (ptr_q == PTR_LAST);

        scan_cnt_d = slot_end_c ? '0 : scan_cnt_q + SCAN_W'(1);
        if (slot_end_c) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
        end

        if (load) begin
            shadow_d = frame_in_c;
        end

        // Taking shadow_d lets a load on the wrap edge bypass straight into active
        if (wrap_c) begin
            active_d     = shadow_d;
            frame_tick_d = 1'b1;
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Digit selection, darkening rules and output pattern for the current slot
    always_comb begin
        nibble_c    = '0;
        dark_c      = 1'b0;
        dp_sel_c    = 1'b0;
        an_onehot_c = '0;
        lz_dark_c   = '0;
        zero_run_c  = lz_en;

        for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
            zero_run_c   = zero_run_c & (active_q.digits[4*k +: 4] == 4'h0);
            lz_dark_c[k] = zero_run_c;
        end

        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (ptr_q == PTR_W'(k)) begin
                nibble_c       = active_q.digits[4*k +: 4];
                dark_c         = active_q.blank[k] | (active_q.blink[k] & ~blink_phase_q)
                                 | lz_dark_c[k];
                dp_sel_c       = active_q.dp[k];
                an_onehot_c[k] = (scan_cnt_q != '0);
            end
        end

        seg_d = apply_polarity(dark_c ? GLYPH_OFF : glyph_c, SEG_ACT_LOW);
        dp_d  = (dp_sel_c & ~dark_c) ^ SEG_ACT_LOW;
        an_d  = an_onehot_c ^ {NUM_DIGITS{AN_ACT_LOW}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt_q    <= '0;
            ptr_q         <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            shadow_q      <= '0;
            active_q      <= '0;
            seg_out       <= {7{SEG_ACT_LOW}};
            dp_out        <= SEG_ACT_LOW;
            an_out        <= {NUM_DIGITS{AN_ACT_LOW}};
            frame_tick    <= 1'b0;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            ptr_q         <= ptr_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            seg_out       <= seg_d;
            dp_out        <= dp_d;
            an_out        <= an_d;
            frame_tick    <= frame_tick_d;
        end
    end

endmodule
